cmd_decode_fsm: RTL and testbench
=================================

# cmd_decode_fsm

Parametrised command fetch-and-decode controller for the polynomial evaluation accelerator. On request from the top-level controller it fetches one command word over a valid/ready handshake, splits it into opcode and two arguments, and range-checks them. It also tracks which coefficient sets have been loaded, so an evaluate on an unloaded set is flagged. Decoded fields and a 2-bit error code are registered and held until the next command completes, and a one-cycle done pulse reports completion.

## Interface
- `OP_W`, 8, opcode width (command word bits [CMD_W-1 -: OP_W])
- `A1_W`, 3, arg1 width (coefficient-set index); `NUM_SETS = 2**A1_W`
- `A2_W`, 5, arg2 width (degree / operand)
- `MAX_DEG`, 10, largest legal degree for opcode 0
- `CMD_W`, OP_W+A1_W+A2_W (16), command word width; derived, not overridable

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `start_get_cmd`  in  1  request one command; sampled only in IDLE
- `cmd_valid`  in  1  command source has a word
- `cmd_data`  in  CMD_W  command word: {opcode, arg1, arg2}
- `cmd_ready`  out  1  high throughout FETCH
- `done_get_cmd`  out  1  one-cycle pulse in DONE
- `command`  out  OP_W  last accepted opcode
- `arg1`  out  A1_W  last accepted arg1
- `arg2`  out  A2_W  last accepted arg2
- `error`  out  2  0 ok, 1 bad opcode, 2 degree > MAX_DEG, 3 set not loaded
- `set_loaded`  out  NUM_SETS  bit i = coefficient set i loaded

## Operation
- States: IDLE, FETCH, CHECK, DONE.
- IDLE -> FETCH when start_get_cmd = 1. While not in IDLE, start_get_cmd is ignored.
- FETCH: cmd_ready = 1. When cmd_valid && cmd_ready, capture cmd_data into an internal register and go to CHECK. Otherwise stay in FETCH indefinitely (no timeout).
- CHECK: decode the captured word. All output updates take effect at the CHECK -> DONE edge.
  - Opcode 0 (SET_COEF), arg2 <= MAX_DEG: load command/arg1/arg2, error = 0, set `set_loaded[arg1]`.
  - Opcode 0, arg2 > MAX_DEG: error = 2.
  - Opcode 1 (EVAL), `set_loaded[arg1]` = 1: load command and arg1, arg2 = 0, error = 0.
  - Opcode 1, `set_loaded[arg1]` = 0: error = 3.
  - Opcode 2 (STORE): load command/arg1/arg2 unchanged, error = 0.
  - Opcode 3 (CLEAR): load command, arg1 = arg2 = 0, error = 0, clear all of `set_loaded`.
  - Any other opcode: error = 1.
  - Whenever error ≠ 0, command/arg1/arg2 and `set_loaded` keep their previous values.
- DONE: done_get_cmd = 1, then IDLE.
- Degree compare is an unsigned comparison at A2_W bits. arg2 = MAX_DEG is legal.

## Timing
- Reset (asynchronous assert): state = IDLE; command, arg1, arg2, error, set_loaded = 0; cmd_ready = 0; done_get_cmd = 0.
- Latency with cmd_valid already high: start sampled at edge 0; FETCH in cycle 1 (handshake completes at edge 1); CHECK in cycle 2; DONE in cycle 3, with the new outputs and done_get_cmd = 1 in the same cycle.
- Minimum command-to-command period is 4 cycles (IDLE, FETCH, CHECK, DONE). start_get_cmd held high in the DONE cycle is not seen; it is sampled in the following IDLE cycle.
- cmd_ready is a registered-state decode: high only in FETCH, and it does not depend combinationally on cmd_valid.
- Reset during FETCH or CHECK: the in-flight word is discarded, no done pulse is produced, and set_loaded is cleared.
- Outputs are stable from DONE until the next CHECK -> DONE edge.

## Structure
- Shared package `poly_cmd_pkg`:
  - opcode constants OP_SET_COEF = 0, OP_EVAL = 1, OP_STORE = 2, OP_CLEAR = 3;
  - error constants ERR_NONE, ERR_OPCODE, ERR_DEGREE, ERR_UNLOADED;
  - state encoding typedef.
- One natural sub-module: `cmd_check`. It is purely combinational: captured word plus set_loaded in, next command/arg1/arg2/error/set_loaded out. The FSM and registers stay in the top level.

## Test plan
- Reset, then start; word {0, 3'd2, 5'd10} -> done in cycle 3 after start; command = 0, arg1 = 2, arg2 = 10, error = 0, set_loaded = 8'h04.
- After the above, {0, 3'd1, 5'd11} -> error = 2; command/arg1/arg2 still 0/2/10; set_loaded = 8'h04.
- {1, 3'd5, x} with set 5 unloaded -> error = 3. Then {1, 3'd2, 5'd7} -> command = 1, arg1 = 2, arg2 = 0, error = 0.
- Opcode 8'h07 -> error = 1, other outputs unchanged. Then {3, x, x} -> command = 3, arg1 = arg2 = 0, set_loaded = 0, error = 0.
- Start with cmd_valid low for 5 cycles -> cmd_ready held high, no done pulse. Raise cmd_valid -> done exactly 2 cycles after the handshake edge.
- Assert reset during CHECK -> all outputs 0, no done pulse. Next start/fetch proceeds normally.

Source files
------------

// File: rtl/poly_cmd_pkg.sv
// Shared definitions for the polynomial accelerator command path.
// Contents:
//   - opcode values understood by the command decoder
//   - the 2-bit error code enumeration
//   - the command fetch FSM state encoding
package poly_cmd_pkg;

  // Opcode values. They are sized to the opcode field at the point of use.
  localparam int unsigned OP_SET_COEF = 32'd0;
  localparam int unsigned OP_EVAL     = 32'd1;
  localparam int unsigned OP_STORE    = 32'd2;
  localparam int unsigned OP_CLEAR    = 32'd3;

  // Error code reported with every completed command.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OPCODE   = 2'd1,
    ERR_DEGREE   = 2'd2,
    ERR_UNLOADED = 2'd3
  } err_e;

  // Command fetch FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/cmd_check.sv
// Combinational decode and range check of one captured command word.
// Ports:
//   word            in   captured command word {opcode, arg1, arg2}
//   set_loaded      in   current coefficient-set loaded flags
//   cur_command     in   currently held opcode
//   cur_arg1        in   currently held arg1
//   cur_arg2        in   currently held arg2
//   next_command    out  opcode to hold after this command
//   next_arg1       out  arg1 to hold after this command
//   next_arg2       out  arg2 to hold after this command
//   next_error      out  error code for this command
//   next_set_loaded out  loaded flags after this command
// On any error the held fields and loaded flags pass through unchanged.
module cmd_check
  import poly_cmd_pkg::*;
#(
  parameter int OP_W     = 8,
  parameter int A1_W     = 3,
  parameter int A2_W     = 5,
  parameter int MAX_DEG  = 10,
  localparam int CMD_W    = OP_W + A1_W + A2_W,
  localparam int NUM_SETS = 2 ** A1_W
) (
  input  logic [CMD_W-1:0]    word,
  input  logic [NUM_SETS-1:0] set_loaded,
  input  logic [OP_W-1:0]     cur_command,
  input  logic [A1_W-1:0]     cur_arg1,
  input  logic [A2_W-1:0]     cur_arg2,
  output logic [OP_W-1:0]     next_command,
  output logic [A1_W-1:0]     next_arg1,
  output logic [A2_W-1:0]     next_arg2,
  output logic [1:0]          next_error,
  output logic [NUM_SETS-1:0] next_set_loaded
);

  logic [OP_W-1:0] op_s;
  logic [A1_W-1:0] a1_s;
  logic [A2_W-1:0] a2_s;

  assign op_s = word[CMD_W-1 -: OP_W];
  assign a1_s = word[A2_W +: A1_W];
  assign a2_s = word[A2_W-1:0];

  // Decode the opcode; everything defaults to "hold" so errors leave state intact.
  always_comb begin
    next_command    = cur_command;
    next_arg1       = cur_arg1;
    next_arg2       = cur_arg2;
    next_error      = ERR_NONE;
    next_set_loaded = set_loaded;
    case (op_s)
      OP_W'(OP_SET_COEF): begin
        // Unsigned compare at the arg2 width; MAX_DEG itself is legal.
        if (a2_s > A2_W'(MAX_DEG)) begin
          next_error = ERR_DEGREE;
        end else begin
          next_command          = op_s;
          next_arg1             = a1_s;
          next_arg2             = a2_s;
          next_set_loaded[a1_s] = 1'b1;
        end
      end
      OP_W'(OP_EVAL): begin
        if (set_loaded[a1_s]) begin
          next_command = op_s;
          next_arg1    = a1_s;
          next_arg2    = {A2_W{1'b0}};
        end else begin
          next_error = ERR_UNLOADED;
        end
      end
      OP_W'(OP_STORE): begin
        next_command = op_s;
        next_arg1    = a1_s;
        next_arg2    = a2_s;
      end
      OP_W'(OP_CLEAR): begin
        next_command    = op_s;
        next_arg1       = {A1_W{1'b0}};
        next_arg2       = {A2_W{1'b0}};
        next_set_loaded = {NUM_SETS{1'b0}};
      end
      default: begin
        next_error = ERR_OPCODE;
      end
    endcase
  end

endmodule

// File: rtl/cmd_decode_fsm.sv
// Command fetch-and-decode controller for the polynomial evaluation accelerator.
// Fetches one command word per request over valid/ready, decodes and range
// checks it, and holds the decoded fields until the next command completes.
// Ports:
//   clk           in   clock
//   reset         in   asynchronous, active-low reset
//   start_get_cmd in   request one command (sampled only in IDLE)
//   cmd_valid     in   command source has a word
//   cmd_data      in   command word {opcode, arg1, arg2}
//   cmd_ready     out  high throughout FETCH
//   done_get_cmd  out  one-cycle completion pulse (DONE state)
//   command       out  last accepted opcode
//   arg1          out  last accepted arg1
//   arg2          out  last accepted arg2
//   error         out  0 ok, 1 bad opcode, 2 degree too large, 3 set not loaded
//   set_loaded    out  bit i set when coefficient set i is loaded
module cmd_decode_fsm
  import poly_cmd_pkg::*;
#(
  parameter int OP_W     = 8,
  parameter int A1_W     = 3,
  parameter int A2_W     = 5,
  parameter int MAX_DEG  = 10,
  localparam int CMD_W    = OP_W + A1_W + A2_W,
  localparam int NUM_SETS = 2 ** A1_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_get_cmd,
  input  logic                cmd_valid,
  input  logic [CMD_W-1:0]    cmd_data,
  output logic                cmd_ready,
  output logic                done_get_cmd,
  output logic [OP_W-1:0]     command,
  output logic [A1_W-1:0]     arg1,
  output logic [A2_W-1:0]     arg2,
  output logic [1:0]          error,
  output logic [NUM_SETS-1:0] set_loaded
);

  state_e                state_r;
  state_e                state_next_s;
  logic [CMD_W-1:0]      word_r;
  logic                  cmd_ready_r;
  logic                  done_r;
  logic [OP_W-1:0]       command_r;
  logic [A1_W-1:0]       arg1_r;
  logic [A2_W-1:0]       arg2_r;
  logic [1:0]            error_r;
  logic [NUM_SETS-1:0]   set_loaded_r;

  logic [OP_W-1:0]       chk_command_s;
  logic [A1_W-1:0]       chk_arg1_s;
  logic [A2_W-1:0]       chk_arg2_s;
  logic [1:0]            chk_error_s;
  logic [NUM_SETS-1:0]   chk_set_loaded_s;

  cmd_check #(
    .OP_W    (OP_W),
    .A1_W    (A1_W),
    .A2_W    (A2_W),
    .MAX_DEG (MAX_DEG)
  ) u_cmd_check (
    .word            (word_r),
    .set_loaded      (set_loaded_r),
    .cur_command     (command_r),
    .cur_arg1        (arg1_r),
    .cur_arg2        (arg2_r),
    .next_command    (chk_command_s),
    .next_arg1       (chk_arg1_s),
    .next_arg2       (chk_arg2_s),
    .next_error      (chk_error_s),
    .next_set_loaded (chk_set_loaded_s)
  );

  // Next-state logic for the fetch/check/done sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_get_cmd) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        // No timeout: wait for the source as long as it takes.
        if (cmd_valid) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_CHECK: state_next_s = ST_DONE;
      ST_DONE:  state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register plus registered decodes of the next state, so cmd_ready
  // and done_get_cmd come straight from flops and never from cmd_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cmd_ready_r <= (state_next_s == ST_FETCH);
      done_r      <= (state_next_s == ST_DONE);
    end
  end

  // Capture the command word on the FETCH handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_r <= {CMD_W{1'b0}};
    end else if ((state_r == ST_FETCH) && cmd_valid) begin
      word_r <= cmd_data;
    end
  end

  // Update decoded outputs only on the CHECK -> DONE edge; held otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      command_r    <= {OP_W{1'b0}};
      arg1_r       <= {A1_W{1'b0}};
      arg2_r       <= {A2_W{1'b0}};
      error_r      <= 2'd0;
      set_loaded_r <= {NUM_SETS{1'b0}};
    end else if (state_r == ST_CHECK) begin
      command_r    <= chk_command_s;
      arg1_r       <= chk_arg1_s;
      arg2_r       <= chk_arg2_s;
      error_r      <= chk_error_s;
      set_loaded_r <= chk_set_loaded_s;
    end
  end

  assign cmd_ready    = cmd_ready_r;
  assign done_get_cmd = done_r;
  assign command      = command_r;
  assign arg1         = arg1_r;
  assign arg2         = arg2_r;
  assign error        = error_r;
  assign set_loaded   = set_loaded_r;

endmodule

// File: tb/tb_cmd_decode_fsm.sv
// Scoreboard bench for cmd_decode_fsm: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_cmd_decode_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_get_cmd;
  logic        cmd_valid;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        done_get_cmd;
  logic [7:0]  command;
  logic [2:0]  arg1;
  logic [4:0]  arg2;
  logic [1:0]  error;
  logic [7:0]  set_loaded;

  cmd_decode_fsm dut (
    .clk           (clk),
    .reset         (reset),
    .start_get_cmd (start_get_cmd),
    .cmd_valid     (cmd_valid),
    .cmd_data      (cmd_data),
    .cmd_ready     (cmd_ready),
    .done_get_cmd  (done_get_cmd),
    .command       (command),
    .arg1          (arg1),
    .arg2          (arg2),
    .error         (error),
    .set_loaded    (set_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] cmd;
    logic [2:0] a1;
    logic [4:0] a2;
    logic [1:0] err;
    logic [7:0] sl;
    int         done_edge;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] op, input logic [2:0] a1, input logic [4:0] a2);
    return {op, a1, a2};
  endfunction

  // Monitor: compare against the oldest expectation on each done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done_get_cmd !== 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check({e.tag, ".command"},    32'(command),    32'(e.cmd));
        check({e.tag, ".arg1"},       32'(arg1),       32'(e.a1));
        check({e.tag, ".arg2"},       32'(arg2),       32'(e.a2));
        check({e.tag, ".error"},      32'(error),      32'(e.err));
        check({e.tag, ".set_loaded"}, 32'(set_loaded), 32'(e.sl));
        check({e.tag, ".done_edge"},  32'(edge_cnt),   32'(e.done_edge));
      end
    end
  end

  // Issue one command. Entered and left #1 after a posedge with the DUT in IDLE.
  task automatic run_cmd(input string tag, input logic [15:0] w, input int delay,
                         input logic [7:0] ec, input logic [2:0] ea1, input logic [4:0] ea2,
                         input logic [1:0] eerr, input logic [7:0] esl);
    exp_t e;
    int   h;
    cmd_data      = w;
    cmd_valid     = (delay == 0);
    start_get_cmd = 1'b1;
    @(posedge clk); #1;
    start_get_cmd = 1'b0;
    for (int i = 0; i < delay; i++) begin
      check({tag, ".ready_wait"}, 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    h = edge_cnt;
    cmd_valid = 1'b0;
    e.tag = tag; e.cmd = ec; e.a1 = ea1; e.a2 = ea2; e.err = eerr; e.sl = esl;
    e.done_edge = h + 1;
    q.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset         = 1'b0;
    start_get_cmd = 1'b0;
    cmd_valid     = 1'b0;
    cmd_data      = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst.command",    32'(command),      32'd0);
    check("rst.error",      32'(error),        32'd0);
    check("rst.set_loaded", 32'(set_loaded),   32'd0);
    check("rst.cmd_ready",  32'(cmd_ready),    32'd0);
    check("rst.done",       32'(done_get_cmd), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_cmd("set2_deg10",  mk(8'd0, 3'd2, 5'd10), 0, 8'd0, 3'd2, 5'd10, 2'd0, 8'h04);
    run_cmd("set1_deg11",  mk(8'd0, 3'd1, 5'd11), 0, 8'd0, 3'd2, 5'd10, 2'd2, 8'h04);
    run_cmd("eval5_unld",  mk(8'd1, 3'd5, 5'd7),  0, 8'd0, 3'd2, 5'd10, 2'd3, 8'h04);
    run_cmd("eval2",       mk(8'd1, 3'd2, 5'd7),  0, 8'd1, 3'd2, 5'd0,  2'd0, 8'h04);
    run_cmd("bad_op7",     mk(8'h07, 3'd3, 5'd3), 0, 8'd1, 3'd2, 5'd0,  2'd1, 8'h04);
    run_cmd("store",       mk(8'd2, 3'd6, 5'd21), 0, 8'd2, 3'd6, 5'd21, 2'd0, 8'h04);
    run_cmd("clear",       mk(8'd3, 3'd5, 5'd9),  0, 8'd3, 3'd0, 5'd0,  2'd0, 8'h00);
    run_cmd("late_valid",  mk(8'd0, 3'd7, 5'd0),  5, 8'd0, 3'd7, 5'd0,  2'd0, 8'h80);

    // Reset while the word sits in CHECK: nothing completes, state clears.
    cmd_data      = mk(8'd0, 3'd1, 5'd1);
    cmd_valid     = 1'b1;
    start_get_cmd = 1'b1;
    @(posedge clk); #1;
    start_get_cmd = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check("rstchk.command",    32'(command),      32'd0);
    check("rstchk.arg1",       32'(arg1),         32'd0);
    check("rstchk.error",      32'(error),        32'd0);
    check("rstchk.set_loaded", 32'(set_loaded),   32'd0);
    check("rstchk.cmd_ready",  32'(cmd_ready),    32'd0);
    @(posedge clk); #1;
    check("rstchk.done",       32'(done_get_cmd), 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rstchk.idle_ready", 32'(cmd_ready),    32'd0);

    run_cmd("post_rst",    mk(8'd0, 3'd4, 5'd3),  0, 8'd0, 3'd4, 5'd3,  2'd0, 8'h10);

    repeat (4) @(posedge clk);
    #2;
    check("pending_expect", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
